// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the 16-bit core front end.
// Holds the opcode encodings that fetch, decode control and the hazard unit
// all agree on, the bubble encoding, and the default datapath widths.
package fetch_stage_pkg;

    localparam int PC_W_DEFAULT    = 16;
    localparam int INSTR_W_DEFAULT = 16;
    localparam int PC_INC_DEFAULT  = 2;

    localparam logic [15:0] RESET_PC_DEFAULT  = 16'h0000;
    // ADD r0,r0,r0: writes r0, which is hard-wired, so it has no architectural effect.
    localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h0000;

    // Opcode lives in instr[15:12].
    typedef enum logic [3:0] {
        OP_B   = 4'hC,
        OP_BR  = 4'hD,
        OP_PCS = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

endpackage

// File: rtl/fetch_stage_pipe_reg.sv
// Generic pipeline register used for the PC and every IF/ID field.
// Ports:
//   clk      core clock
//   rst      synchronous, active-high reset to RST_VAL
//   clr      synchronous clear to clr_val (beats en)
//   clr_val  value loaded on clr
//   en       load d when set, otherwise hold
//   d / q    data in / registered data out
module fetch_stage_pipe_reg #(
    parameter int           W       = 16,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] clr_val,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of evaluation order; the reset lives
    // inside the clocked branch, making it synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= clr_val;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register.
// Holds the PC, addresses the asynchronous-read instruction memory and
// registers {instr, PC+PC_INC, valid} into IF/ID. Handles hazard stalls,
// decode-resolved branch redirects and the HLT freeze.
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   stall           hold PC, IF/ID and halt state this cycle
//   redirect        taken branch: load redirect_pc, squash IF/ID, clear halt
//   redirect_pc     branch target (passed through unaligned as given)
//   imem_addr       instruction memory address (= current PC)
//   imem_data       instruction read data, valid in the same cycle
//   ifid_instr      registered instruction for decode
//   ifid_pc_plus2   registered PC+PC_INC of that instruction
//   ifid_valid      1 = real instruction, 0 = bubble
//   fetch_halted    1 = HLT fetched, PC frozen
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                PC_W      = PC_W_DEFAULT,
    parameter int                INSTR_W   = INSTR_W_DEFAULT,
    parameter logic [PC_W-1:0]   RESET_PC  = PC_W'(RESET_PC_DEFAULT),
    parameter int                PC_INC    = PC_INC_DEFAULT,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc_plus2,
    output logic               ifid_valid,
    output logic               fetch_halted
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_plus;
    logic            hlt_seen;
    logic            fetch_ok;
    logic            advance_pc;
    logic            ifid_bubble;

    assign imem_addr = pc_q;
    // Natural PC_W-bit wrap: FFFE + 2 -> 0000.
    assign pc_plus   = pc_q + PC_W'(PC_INC);
    assign hlt_seen  = (imem_data[INSTR_W-1 -: 4] == OP_HLT);

    // Redirect is wired to each register's clear port, which outranks enable,
    // so it wins over stall and halt without appearing in the terms below.
    assign fetch_ok    = !stall && !fetch_halted;
    // HLT is latched into IF/ID but the PC stays on the HLT address.
    assign advance_pc  = fetch_ok && !hlt_seen;
    // While halted, decode sees a fresh bubble every unstalled cycle.
    assign ifid_bubble = redirect || (!stall && fetch_halted);

    fetch_stage_pipe_reg #(.W(PC_W), .RST_VAL(RESET_PC)) u_pc (
        .clk     (clk),
        .rst     (rst),
        .clr     (redirect),
        .clr_val (redirect_pc),
        .en      (advance_pc),
        .d       (pc_plus),
        .q       (pc_q)
    );

    fetch_stage_pipe_reg #(.W(INSTR_W), .RST_VAL(NOP_INSTR)) u_ifid_instr (
        .clk     (clk),
        .rst     (rst),
        .clr     (ifid_bubble),
        .clr_val (NOP_INSTR),
        .en      (fetch_ok),
        .d       (imem_data),
        .q       (ifid_instr)
    );

    fetch_stage_pipe_reg #(.W(PC_W), .RST_VAL('0)) u_ifid_pc_plus2 (
        .clk     (clk),
        .rst     (rst),
        .clr     (ifid_bubble),
        .clr_val ('0),
        .en      (fetch_ok),
        .d       (pc_plus),
        .q       (ifid_pc_plus2)
    );

    fetch_stage_pipe_reg #(.W(1), .RST_VAL(1'b0)) u_ifid_valid (
        .clk     (clk),
        .rst     (rst),
        .clr     (ifid_bubble),
        .clr_val (1'b0),
        .en      (fetch_ok),
        .d       (1'b1),
        .q       (ifid_valid)
    );

    // Halt sets on the cycle HLT is captured and only a redirect or reset clears it.
    fetch_stage_pipe_reg #(.W(1), .RST_VAL(1'b0)) u_halted (
        .clk     (clk),
        .rst     (rst),
        .clr     (redirect),
        .clr_val (1'b0),
        .en      (fetch_ok && hlt_seen),
        .d       (1'b1),
        .q       (fetch_halted)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by a
// randomized run, all compared against a cycle-level behavioural model.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus2;
    logic        ifid_valid;
    logic        fetch_halted;

    // 256-byte instruction memory; higher addresses alias onto it.
    logic [15:0] mem [0:255];
    assign imem_data = mem[imem_addr[7:0]];

    // Reference model state.
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_pp2;
    logic        m_valid;
    logic        m_halted;

    int n_err;
    int n_checks;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus2 (ifid_pc_plus2),
        .ifid_valid    (ifid_valid),
        .fetch_halted  (fetch_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fill_mem(input bit allow_hlt);
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'($urandom);
            if (!allow_hlt && mem[i][15:12] == 4'hF) mem[i][15:12] = 4'h0;
        end
    endtask

    // Apply one cycle of inputs, advance the model by one clock, then compare
    // every output 1 time unit after the edge.
    task automatic step(input logic r, input logic s, input logic rd,
                        input logic [15:0] rpc, input string tag);
        logic [15:0] word;
        rst = r; stall = s; redirect = rd; redirect_pc = rpc;
        word = mem[m_pc[7:0]];
        if (r) begin
            m_pc = 16'h0000; m_instr = 16'h0000; m_pp2 = 16'h0000;
            m_valid = 1'b0; m_halted = 1'b0;
        end else if (rd) begin
            m_pc = rpc; m_instr = 16'h0000; m_pp2 = 16'h0000;
            m_valid = 1'b0; m_halted = 1'b0;
        end else if (s) begin
            // everything holds
        end else if (m_halted) begin
            m_instr = 16'h0000; m_pp2 = 16'h0000; m_valid = 1'b0;
        end else begin
            m_instr = word;
            m_pp2   = 16'(m_pc + 16'd2);
            m_valid = 1'b1;
            if (word[15:12] == 4'hF) m_halted = 1'b1;
            else                     m_pc = 16'(m_pc + 16'd2);
        end
        @(posedge clk);
        #1;
        check({tag, "_pc"},     imem_addr,                m_pc);
        check({tag, "_instr"},  ifid_instr,               m_instr);
        check({tag, "_pp2"},    ifid_pc_plus2,            m_pp2);
        check({tag, "_valid"},  {15'd0, ifid_valid},      {15'd0, m_valid});
        check({tag, "_halted"}, {15'd0, fetch_halted},    {15'd0, m_halted});
    endtask

    initial begin
        n_err = 0; n_checks = 0;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        m_pc = 16'h0000; m_instr = 16'h0000; m_pp2 = 16'h0000;
        m_valid = 1'b0; m_halted = 1'b0;
        fill_mem(1'b0);
        mem[8'h08] = 16'hF000;
        mem[8'h20] = 16'hF123;

        // Reset state.
        step(1'b1, 1'b0, 1'b0, 16'h0000, "rst");
        check("rst_pc_abs", imem_addr, 16'h0000);
        check("rst_valid_abs", {15'd0, ifid_valid}, 16'h0000);

        // Sequential fetch 0 -> 2 -> 4.
        step(1'b0, 1'b0, 1'b0, 16'h0000, "seq");
        check("seq_pp2_abs", ifid_pc_plus2, 16'h0002);
        step(1'b0, 1'b0, 1'b0, 16'h0000, "seq");
        check("seq_pc_abs", imem_addr, 16'h0004);

        // Stall three cycles at pc 4, then resume.
        repeat (3) step(1'b0, 1'b1, 1'b0, 16'h0000, "stall");
        check("stall_pc_abs", imem_addr, 16'h0004);
        check("stall_pp2_abs", ifid_pc_plus2, 16'h0004);
        step(1'b0, 1'b0, 1'b0, 16'h0000, "resume");
        check("resume_pc_abs", imem_addr, 16'h0006);
        step(1'b0, 1'b0, 1'b0, 16'h0000, "seq");

        // HLT at 8: captured once, then bubbles with PC frozen.
        step(1'b0, 1'b0, 1'b0, 16'h0000, "hlt");
        check("hlt_instr_abs", ifid_instr, 16'hF000);
        check("hlt_pc_abs", imem_addr, 16'h0008);
        repeat (2) step(1'b0, 1'b0, 1'b0, 16'h0000, "halted");
        check("halted_valid_abs", {15'd0, ifid_valid}, 16'h0000);

        // Redirect out of halt to 0x10, fetch resumes there.
        step(1'b0, 1'b0, 1'b1, 16'h0010, "redir10");
        check("redir10_halted_abs", {15'd0, fetch_halted}, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000, "after10");
        check("after10_pc_abs", imem_addr, 16'h0012);

        // Redirect beats a simultaneous stall.
        step(1'b0, 1'b1, 1'b1, 16'h0040, "redir40");
        check("redir40_pc_abs", imem_addr, 16'h0040);
        check("redir40_instr_abs", ifid_instr, 16'h0000);

        // PC wrap at FFFE.
        step(1'b0, 1'b0, 1'b1, 16'hFFFE, "to_fffe");
        step(1'b0, 1'b0, 1'b0, 16'h0000, "wrap");
        check("wrap_pc_abs", imem_addr, 16'h0000);
        check("wrap_pp2_abs", ifid_pc_plus2, 16'h0000);

        // Unaligned redirect target passes through.
        step(1'b0, 1'b0, 1'b1, 16'h0033, "odd");
        check("odd_pc_abs", imem_addr, 16'h0033);

        // Stall with HLT on the bus, then HLT captured, then reset while halted.
        step(1'b0, 1'b0, 1'b1, 16'h0020, "to20");
        step(1'b0, 1'b1, 1'b0, 16'h0000, "stall_hlt");
        check("stall_hlt_halted_abs", {15'd0, fetch_halted}, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000, "hlt20");
        check("hlt20_halted_abs", {15'd0, fetch_halted}, 16'h0001);
        step(1'b1, 1'b0, 1'b0, 16'h0000, "rst_halted");
        check("rst_halted_pc_abs", imem_addr, 16'h0000);
        check("rst_halted_h_abs", {15'd0, fetch_halted}, 16'h0000);

        // Randomized run against the model, HLTs included.
        fill_mem(1'b1);
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 12,
                 16'($urandom),
                 "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
